// File: rtl/comparator_pkg.sv
// Shared types and helpers for the serial and combinational magnitude comparators.
// Results are encoded {gt, lt, eq} so exactly one bit is set after a decision.
package comparator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] RES_GT   = 3'b100;
    localparam logic [2:0] RES_LT   = 3'b010;
    localparam logic [2:0] RES_EQ   = 3'b001;

    // Lower-significance tiebreak: gt wins over lt, anything else (eqi or
    // invalid/all-zero cascade) resolves to equal, so eqi itself never matters.
    function automatic logic [2:0] cascade_resolve(input logic gti, input logic lti);
        if (gti)
            return RES_GT;
        else if (lti)
            return RES_LT;
        else
            return RES_EQ;
    endfunction

endpackage

// File: rtl/bit_compare_cell.sv
// Combinational 1-bit magnitude compare.
module bit_compare_cell (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);
    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);
endmodule

// File: rtl/serial_msb_comparator.sv
// Bit-serial MSB-first unsigned comparator with early exit on the first differing bit;
// the captured cascade inputs break ties when all operand bits match.
module serial_msb_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             gti,
    input  logic             lti,
    input  logic             eqi,
    output logic             busy,
    output logic             done,
    output logic             gto,
    output logic             lto,
    output logic             eqo
);
    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [WIDTH-1:0] sh_a, sh_a_nx;
    logic [WIDTH-1:0] sh_b, sh_b_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             cas_gt, cas_gt_nx;
    logic             cas_lt, cas_lt_nx;
    logic [2:0]       res, res_nx;
    logic             done_nx;
    logic             bit_gt, bit_lt, bit_eq;

    // eqi carries no information once gti/lti are known.
    logic unused_eqi;
    assign unused_eqi = eqi;

    bit_compare_cell u_cell (
        .a  (sh_a[WIDTH-1]),
        .b  (sh_b[WIDTH-1]),
        .gt (bit_gt),
        .lt (bit_lt),
        .eq (bit_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            cnt    <= '0;
            cas_gt <= 1'b0;
            cas_lt <= 1'b0;
            res    <= RES_NONE;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            sh_a   <= sh_a_nx;
            sh_b   <= sh_b_nx;
            cnt    <= cnt_nx;
            cas_gt <= cas_gt_nx;
            cas_lt <= cas_lt_nx;
            res    <= res_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sh_a_nx   = sh_a;
        sh_b_nx   = sh_b;
        cnt_nx    = cnt;
        cas_gt_nx = cas_gt;
        cas_lt_nx = cas_lt;
        res_nx    = res;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SCAN;
                    sh_a_nx   = A;
                    sh_b_nx   = B;
                    cnt_nx    = CW'(WIDTH - 1);
                    cas_gt_nx = gti;
                    cas_lt_nx = lti;
                end
            end
            SCAN: begin
                if (bit_gt) begin
                    res_nx   = RES_GT;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (bit_lt) begin
                    res_nx   = RES_LT;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (bit_eq && (cnt != '0)) begin
                    sh_a_nx = {sh_a[WIDTH-2:0], 1'b0};
                    sh_b_nx = {sh_b[WIDTH-2:0], 1'b0};
                    cnt_nx  = cnt - 1'b1;
                end else begin
                    res_nx   = cascade_resolve(cas_gt, cas_lt);
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy            = (state == SCAN);
    assign {gto, lto, eqo} = res;

endmodule

// File: tb/tb_serial_msb_comparator.sv
// Directed bench for serial_msb_comparator: vector table plus back-to-back,
// ignored-start and mid-scan reset sequences.
module tb_serial_msb_comparator;
    localparam int WIDTH = 6;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             gti = 1'b0, lti = 1'b0, eqi = 1'b0;
    logic             busy, done, gto, lto, eqo;

    int n_chk  = 0;
    int n_fail = 0;

    serial_msb_comparator #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .gti(gti), .lti(lti), .eqi(eqi),
        .busy(busy), .done(done), .gto(gto), .lto(lto), .eqo(eqo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             gi, li, ei;
        logic [2:0]       exp_res;   // {gto, lto, eqo}
        int               exp_lat;   // edges after the accepting edge
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive start before an edge; returns with time #1 after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic gi, input logic li, input logic ei);
        @(negedge clk);
        A = a; B = b; gti = gi; lti = li; eqi = ei; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = '0; B = '0; gti = 1'b0; lti = 1'b0; eqi = 1'b0;
    endtask

    // Count edges until done; returns 99 on timeout, leaving time in the done cycle.
    task automatic wait_done(output int lat);
        lat = 99;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int done_seen;

        vecs[0]  = '{6'd28, 6'd28, 1'b0, 1'b0, 1'b1, 3'b001, 6};
        vecs[1]  = '{6'd40, 6'd24, 1'b0, 1'b0, 1'b1, 3'b100, 1};
        vecs[2]  = '{6'd28, 6'd29, 1'b0, 1'b0, 1'b1, 3'b010, 6};
        vecs[3]  = '{6'd17, 6'd17, 1'b1, 1'b0, 1'b0, 3'b100, 6};
        vecs[4]  = '{6'd17, 6'd17, 1'b1, 1'b1, 1'b0, 3'b100, 6};
        vecs[5]  = '{6'd17, 6'd17, 1'b0, 1'b1, 1'b0, 3'b010, 6};
        vecs[6]  = '{6'd17, 6'd17, 1'b0, 1'b0, 1'b0, 3'b001, 6};
        vecs[7]  = '{6'd17, 6'd17, 1'b0, 1'b1, 1'b1, 3'b010, 6};
        vecs[8]  = '{6'd63, 6'd0,  1'b0, 1'b0, 1'b1, 3'b100, 1};
        vecs[9]  = '{6'd0,  6'd63, 1'b1, 1'b0, 1'b0, 3'b010, 1};
        vecs[10] = '{6'd32, 6'd48, 1'b0, 1'b0, 1'b1, 3'b010, 2};
        vecs[11] = '{6'd7,  6'd6,  1'b0, 1'b1, 1'b0, 3'b100, 6};
        vecs[12] = '{6'd9,  6'd11, 1'b1, 1'b0, 1'b0, 3'b010, 5};

        // Reset state
        #12;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_res",  int'({gto, lto, eqo}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].gi, vecs[i].li, vecs[i].ei);
            chk($sformatf("v%0d_busy_start", i), int'(busy), 1);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_result", i), int'({gto, lto, eqo}), int'(vecs[i].exp_res));
            chk($sformatf("v%0d_busy_done", i), int'(busy), 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
            chk($sformatf("v%0d_res_hold", i), int'({gto, lto, eqo}), int'(vecs[i].exp_res));
        end

        // Start while busy is ignored; back-to-back start in the done cycle.
        issue(6'd5, 6'd5, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        A = 6'd63; B = 6'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = '0; B = '0;
        chk("ignored_busy", int'(busy), 1);
        chk("ignored_no_done", int'(done), 0);
        lat = 99;
        for (int n = 3; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("ignored_latency", lat, 6);
        chk("ignored_result", int'({gto, lto, eqo}), 1);
        A = 6'd40; B = 6'd24; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = '0; B = '0;
        chk("b2b_busy", int'(busy), 1);
        chk("b2b_done_low", int'(done), 0);
        chk("b2b_res_held", int'({gto, lto, eqo}), 1);
        @(posedge clk); #1;
        chk("b2b_done", int'(done), 1);
        chk("b2b_result", int'({gto, lto, eqo}), 4);

        // Mid-scan asynchronous reset aborts with no done.
        issue(6'd28, 6'd28, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_res", int'({gto, lto, eqo}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        done_seen = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_res_after", int'({gto, lto, eqo}), 0);
        issue(6'd28, 6'd29, 1'b0, 1'b0, 1'b1);
        wait_done(lat);
        chk("post_abort_latency", lat, 6);
        chk("post_abort_result", int'({gto, lto, eqo}), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
